uart_frame_arbiter: RTL
=======================

Name: uart_frame_arbiter

Overview:
- Shares the single UART byte transmitter between two 24-bit sample FIFOs: source 0 carries MEMS SPI samples, source 1 carries STM samples.
- Round-robin arbitration at frame granularity.
- Each granted frame is sent as: header byte, source-ID byte, WORDS_PER_FRAME words (3 bytes each, MSB first), trailer byte.
- Owns the FIFO read strobes and the transmitter start strobe.

Parameters:
WORDS_PER_FRAME, 8, 24-bit words per frame (1..255)
USEDW_W, 8, width of FIFO fill-level inputs
HEADER, 8'h19, first byte of every frame
TRAILER, 8'h00, last byte of every frame

Ports:
CLK  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = frames may start; 0 = finish current frame, then idle
s0_data  input  24  source 0 FIFO q (normal mode, valid 1 cycle after rdreq)
s0_usedw  input  USEDW_W  source 0 fill level
s0_rdreq  output  1  source 0 read strobe, 1-cycle pulse
s1_data  input  24  source 1 FIFO q
s1_usedw  input  USEDW_W  source 1 fill level
s1_rdreq  output  1  source 1 read strobe
tx_ready  input  1  UART transmitter idle/accepting
tx_data  output  8  byte to transmit, held stable from tx_start until next tx_start
tx_start  output  1  1-cycle pulse, byte launch
busy  output  1  1 from grant until trailer accepted
grant  output  1  source currently/last granted
frame_done  output  1  1-cycle pulse after trailer tx_start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0: tx_data=0, tx_start=0, s0_rdreq=0, s1_rdreq=0, busy=0, grant=0, frame_done=0. Round-robin pointer = source 0 first.
- Reset asserted mid-frame aborts immediately. No trailer is sent. FIFO words already read are lost.
- Eligibility: source i is eligible when si_usedw >= WORDS_PER_FRAME.
- IDLE: when enable=1 and at least one source is eligible, grant goes to it.
  - Both eligible: grant the source that did not win the previous frame. After reset, source 0 wins.
  - Go to HDR with busy=1 and grant latched for the whole frame.
- Byte send rule (HDR, SRC, B2, B1, B0, TRL):
  - Wait for tx_ready=1, then drive tx_data and pulse tx_start for exactly one cycle.
  - The next cycle is a mandatory GAP cycle in which tx_ready is ignored (covers transmitter ready deassert latency).
  - Never two tx_start pulses within 2 cycles.
- Byte sequence:
  - HDR sends HEADER.
  - SRC sends {7'b0, grant}.
  - RD: pulse the granted rdreq for 1 cycle.
  - LATCH: capture the granted si_data into a 24-bit word register.
  - B2 sends word[23:16], B1 sends word[15:8], B0 sends word[7:0].
  - Word counter increments after B0. If count < WORDS_PER_FRAME, return to RD; else go to TRL.
  - TRL sends TRAILER. frame_done pulses the cycle after its tx_start. busy drops in that same cycle. Return to IDLE.
- Latency: with tx_ready held 1, HDR tx_start comes 1 cycle after the grant decision. Between consecutive words there are 2 extra cycles (RD, LATCH).
- No underflow by construction: eligibility guarantees WORDS_PER_FRAME words. Only the granted source's rdreq may ever pulse, and rdreq of the other source stays 0.
- enable falling mid-frame has no effect until the frame completes. IDLE then holds while enable=0.
- Fill level of the non-granted source is ignored during a frame. The arbiter re-evaluates in IDLE the cycle after frame_done, so back-to-back frames are possible.
- Word counter width is 8 bits and is cleared on every grant.

Test Plan:
- Reset: hold reset=0 with s0_usedw=20 → all outputs 0, no tx_start. Release with enable=1, tx_ready=1 → grant=0, bytes 19,00 then 24 data bytes then 00; frame_done pulses once; exactly 8 s0_rdreq pulses.
- Data ordering: FIFO0 returns 0xA1B2C3 → tx_data sequence A1,B2,C3 for that word. No tx_start on consecutive cycles.
- Round robin: both usedw=16, enable=1 → frames granted 0,1,0,1; the SRC byte alternates 00/01; s1_rdreq stays 0 during source-0 frames.
- Backpressure: tx_ready held 0 for 50 cycles after the HDR tx_start's GAP cycle → no tx_start during stall. The SRC byte launches on the first cycle tx_ready=1. Byte count per frame is still 27.
- Threshold: s0_usedw=7 → stays IDLE, busy=0. Raise to 8 → frame starts. Drop enable mid-frame → frame completes, then no new grant despite usedw=8.
- Async reset mid-frame after 5 bytes → outputs 0 immediately, no trailer. After release with source 1 eligible and source 0 empty, the next frame grants source 1 cleanly.

Source files
------------

// File: rtl/uart_frame_arbiter.sv
// Round-robin frame arbiter sharing one UART byte transmitter between two 24-bit sample FIFOs.
// HDR launches 1 cycle after grant; every byte waits for tx_ready and is followed by a dead cycle.
module uart_frame_arbiter #(
   parameter int unsigned WORDS_PER_FRAME = 8,
   parameter int unsigned USEDW_W         = 8,
   parameter logic [7:0]  HEADER          = 8'h19,
   parameter logic [7:0]  TRAILER         = 8'h00
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               enable,
   input  logic [23:0]        s0_data,
   input  logic [USEDW_W-1:0] s0_usedw,
   output logic               s0_rdreq,
   input  logic [23:0]        s1_data,
   input  logic [USEDW_W-1:0] s1_usedw,
   output logic               s1_rdreq,
   input  logic               tx_ready,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   output logic               busy,
   output logic               grant,
   output logic               frame_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_SRC, S_RD, S_LATCH, S_B2, S_B1, S_B0, S_TRL, S_DONE
   } state_t;

   localparam logic [USEDW_W:0] WPF_V = (USEDW_W + 1)'(WORDS_PER_FRAME);
   localparam logic [7:0]       WPF_C = 8'(WORDS_PER_FRAME);

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        prio_q, prio_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [23:0] word_q, word_d;
   logic        gap_q, gap_d;
   logic [7:0]  tx_data_q, tx_data_d;

   logic        elig0, elig1;
   logic        send_c, tx_start_c;
   logic [7:0]  byte_c;
   state_t      nxt_c;

   assign elig0 = ({1'b0, s0_usedw} >= WPF_V);
   assign elig1 = ({1'b0, s1_usedw} >= WPF_V);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      prio_d     = prio_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      gap_d      = 1'b0;
      tx_data_d  = tx_data_q;
      tx_start_c = 1'b0;
      send_c     = 1'b0;
      byte_c     = 8'h00;
      nxt_c      = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable && (elig0 || elig1)) begin
               grant_d = (elig0 && elig1) ? prio_q : elig1;
               prio_d  = ~grant_d;
               cnt_d   = 8'd0;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            send_c = 1'b1;
            byte_c = HEADER;
            nxt_c  = S_SRC;
         end
         S_SRC: begin
            send_c = 1'b1;
            byte_c = {7'b0, grant_q};
            nxt_c  = S_RD;
         end
         S_RD:    state_d = S_LATCH;
         S_LATCH: begin
            word_d  = grant_q ? s1_data : s0_data;
            state_d = S_B2;
         end
         S_B2: begin
            send_c = 1'b1;
            byte_c = word_q[23:16];
            nxt_c  = S_B1;
         end
         S_B1: begin
            send_c = 1'b1;
            byte_c = word_q[15:8];
            nxt_c  = S_B0;
         end
         S_B0: begin
            send_c = 1'b1;
            byte_c = word_q[7:0];
            nxt_c  = ((cnt_q + 8'd1) < WPF_C) ? S_RD : S_TRL;
         end
         S_TRL: begin
            send_c = 1'b1;
            byte_c = TRAILER;
            nxt_c  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // gap_q blanks the cycle after a launch, when tx_ready may still be stale
      if (send_c && !gap_q && tx_ready) begin
         tx_start_c = 1'b1;
         tx_data_d  = byte_c;
         gap_d      = 1'b1;
         state_d    = nxt_c;
         if (state_q == S_B0) cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         grant_q   <= 1'b0;
         prio_q    <= 1'b0;
         cnt_q     <= 8'd0;
         word_q    <= 24'd0;
         gap_q     <= 1'b0;
         tx_data_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         prio_q    <= prio_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         gap_q     <= gap_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_start   = tx_start_c;
   assign tx_data    = tx_data_d;
   assign s0_rdreq   = (state_q == S_RD) && !grant_q;
   assign s1_rdreq   = (state_q == S_RD) && grant_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign grant      = grant_q;
   assign frame_done = (state_q == S_DONE);

endmodule
